// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the writeback slice: instruction codes,
// register specifiers and the writeback FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] REG_ESP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_POP2 = 2'd1,
    S_HALT = 2'd2
  } wb_state_t;

  // Codes C..F are not defined by the ISA and stop the machine with an error.
  function automatic logic is_invalid(input logic [3:0] code);
    return code >= 4'hC;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 architectural register file: one synchronous write port, two
// combinational read ports, synchronous clear on reset. Specifiers outside
// the implemented range (including 4'hF) read as zero and are never written.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr_a,
  input  logic [3:0]   raddr_b,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] NREGS_U = 5'(NREGS);

  logic [W-1:0] regs [NREGS];

  logic waddr_ok;
  logic raddr_a_ok;
  logic raddr_b_ok;

  assign waddr_ok   = ({1'b0, waddr}   < NREGS_U);
  assign raddr_a_ok = ({1'b0, raddr_a} < NREGS_U);
  assign raddr_b_ok = ({1'b0, raddr_b} < NREGS_U);

  // Storage: clear everything on reset, otherwise commit the single write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata_a = raddr_a_ok ? regs[raddr_a[AW-1:0]] : '0;
    rdata_b = raddr_b_ok ? regs[raddr_b[AW-1:0]] : '0;
  end

endmodule

// File: rtl/writeback.sv
// Y86 writeback stage: commits retiring results to the register file,
// splits popl into two write cycles, tracks halt/err and retired count.
// Optional macro WRITEBACK_BYPASS_EN forwards the in-flight write to the
// decode read ports in the same cycle.
module writeback
  import y86_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic         cnd,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic [W-1:0] valE,
  input  logic [W-1:0] valM,
  input  logic [3:0]   srcA,
  input  logic [3:0]   srcB,
  output logic [W-1:0] rvalA,
  output logic [W-1:0] rvalB,
  output logic         halted,
  output logic         err,
  output logic [W-1:0] retired
);

  localparam logic [4:0] NREGS_U = 5'(NREGS);

  wb_state_t    state;
  wb_state_t    state_next;
  logic         accept;
  logic [3:0]   pop_ra;
  logic [W-1:0] pop_valm;
  logic         err_q;
  logic [W-1:0] retired_q;

  logic         wr_req;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;

  assign accept = in_valid & in_ready;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: popl detours through POP2, halt/invalid codes stop.
  always_comb begin
    state_next = state;
    unique case (state)
      S_RUN: begin
        if (accept) begin
          if (icode == I_POPL) begin
            state_next = S_POP2;
          end else if (icode == I_HALT || is_invalid(icode)) begin
            state_next = S_HALT;
          end
        end
      end
      S_POP2:  state_next = S_RUN;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RUN;
    endcase
  end

  // FSM outputs: handshake, halt flag and the single register write port.
  always_comb begin
    in_ready = (state == S_RUN);
    halted   = (state == S_HALT);
    wr_req   = 1'b0;
    wr_addr  = REG_NONE;
    wr_data  = '0;
    if (state == S_POP2) begin
      wr_req  = 1'b1;
      wr_addr = pop_ra;
      wr_data = pop_valm;
    end else if (accept) begin
      unique case (icode)
        I_RRMOVL: begin
          wr_req  = cnd;
          wr_addr = rB;
          wr_data = valE;
        end
        I_IRMOVL, I_OPL: begin
          wr_req  = 1'b1;
          wr_addr = rB;
          wr_data = valE;
        end
        I_MRMOVL: begin
          wr_req  = 1'b1;
          wr_addr = rA;
          wr_data = valM;
        end
        I_CALL, I_RET, I_PUSHL, I_POPL: begin
          wr_req  = 1'b1;
          wr_addr = REG_ESP;
          wr_data = valE;
        end
        default: wr_req = 1'b0;
      endcase
    end
    wr_en = wr_req && (wr_addr != REG_NONE) && ({1'b0, wr_addr} < NREGS_U);
  end

  // Deferred popl destination and data for the POP2 write.
  always_ff @(posedge clock) begin
    if (reset) begin
      pop_ra   <= REG_NONE;
      pop_valm <= '0;
    end else if (accept && icode == I_POPL) begin
      pop_ra   <= rA;
      pop_valm <= valM;
    end
  end

  // Retirement bookkeeping: count every accept, latch err on invalid codes.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      retired_q <= retired_q + 1'b1;
      if (is_invalid(icode)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign retired = retired_q;

  y86_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (srcA),
    .raddr_b (srcB),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

`ifdef WRITEBACK_BYPASS_EN
  // Decode read ports with same-cycle forwarding of the active write.
  always_comb begin
    rvalA = rf_a;
    rvalB = rf_b;
    if (wr_en && srcA == wr_addr) rvalA = wr_data;
    if (wr_en && srcB == wr_addr) rvalB = wr_data;
  end
`else
  // Decode read ports return stored values only.
  always_comb begin
    rvalA = rf_a;
    rvalB = rf_b;
  end
`endif

endmodule
